// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock-enable generator.
package clk_div_pkg;

  localparam int DEF_N_CH    = 4;
  localparam int DEF_CNT_W   = 26;
  localparam int DEF_DIV_VAL = 262144;

  // Select width of a channel index; a single channel still needs one bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_CH_W = ch_width(DEF_N_CH);

  // A write target is ready unless it is a real channel already holding a divisor.
  // Out-of-range targets always look ready so the writer never stalls on them.
  function automatic logic cfg_ready_decode(input logic in_range, input logic pend_bit);
    return !in_range || !pend_bit;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider slice: counter, active and pending divisor, tick and square-wave outputs.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int DEF_DIV = DEF_DIV_VAL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_pending,
  output logic             o_tick,
  output logic             o_clk_div
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_pend_div;
  logic             r_pending;
  logic             r_tick;
  logic             r_clk_div;

  logic [CNT_W-1:0] w_div_m1;
  logic [CNT_W-1:0] w_cnt_p1;
  logic             w_terminal;

  assign w_div_m1   = r_div - CNT_W'(1);
  assign w_cnt_p1   = r_cnt + CNT_W'(1);
  assign w_terminal = (r_cnt == w_div_m1);

  // Divider state: sync beats stop, stop beats freeze, and a new divisor only lands on a period boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_div      <= CNT_W'(DEF_DIV);
      r_pend_div <= '0;
      r_pending  <= 1'b0;
      r_tick     <= 1'b0;
      r_clk_div  <= 1'b0;
    end else begin
      if (i_sync) begin
        r_cnt     <= '0;
        r_tick    <= 1'b0;
        r_clk_div <= 1'b0;
        if (r_pending) begin
          r_div     <= r_pend_div;
          r_pending <= 1'b0;
        end
      end else if (r_div == '0) begin
        r_cnt     <= '0;
        r_tick    <= 1'b0;
        r_clk_div <= 1'b0;
        if (r_pending) begin
          r_div     <= r_pend_div;
          r_pending <= 1'b0;
        end
      end else if (!i_en) begin
        r_tick <= 1'b0;
      end else if (w_terminal) begin
        r_cnt  <= '0;
        r_tick <= 1'b1;
        if (r_pending) begin
          r_div     <= r_pend_div;
          r_pending <= 1'b0;
          r_clk_div <= (r_pend_div == '0) ? 1'b0 : ~r_clk_div;
        end else begin
          r_clk_div <= ~r_clk_div;
        end
      end else begin
        r_cnt  <= w_cnt_p1;
        r_tick <= 1'b0;
      end
      if (i_load) begin
        r_pend_div <= i_load_val;
        r_pending  <= 1'b1;
      end
    end
  end

  assign o_pending = r_pending;
  assign o_tick    = r_tick;
  assign o_clk_div = r_clk_div;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock-enable generator with a shared divisor write port.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter  int N_CH    = DEF_N_CH,
  parameter  int CNT_W   = DEF_CNT_W,
  parameter  int DEF_DIV = DEF_DIV_VAL,
  localparam int CH_W    = ch_width(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  en,
  input  logic             sync,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  output logic [N_CH-1:0]  pending,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  clk_div
);

  logic            w_in_range;
  logic            w_pend_sel;
  logic            w_accept;
  logic [N_CH-1:0] w_load;

  assign w_in_range = ({1'b0, cfg_ch} < (CH_W + 1)'(N_CH));

  // Pick the pending flag of the addressed channel; unmatched indices read as not pending.
  always_comb begin
    w_pend_sel = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        w_pend_sel = pending[i];
      end
    end
  end

  assign cfg_ready = cfg_ready_decode(w_in_range, w_pend_sel);
  assign w_accept  = cfg_valid && cfg_ready;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
    assign w_load[gi] = w_accept && (cfg_ch == CH_W'(gi));

    clk_div_chan #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .i_en       (en[gi]),
      .i_sync     (sync),
      .i_load     (w_load[gi]),
      .i_load_val (cfg_div),
      .o_pending  (pending[gi]),
      .o_tick     (tick[gi]),
      .o_clk_div  (clk_div[gi])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi with 4 channels, 8-bit counters and a reset divisor of 4.
// Cycle numbers count posedges after reset release; outputs are sampled 1 ns after each edge.
module tb_clk_div_multi;

  localparam int N_CH  = 4;
  localparam int CNT_W = 8;
  localparam int DEFD  = 4;
  localparam int CH_W  = 2;

  logic             clk;
  logic             rst;
  logic [N_CH-1:0]  en;
  logic             sync;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic [N_CH-1:0]  pending;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  clk_div;

  int checkCount = 0;
  int passCount  = 0;
  int cyc        = 0;

  // Expected tick / clk_div after edges 17..24, once ch1 has switched to a divisor of 3.
  logic [3:0] tickB [0:7] = '{4'h0, 4'h0, 4'h2, 4'hD, 4'h0, 4'h2, 4'h0, 4'hD};
  logic [3:0] divB  [0:7] = '{4'h0, 4'h0, 4'h2, 4'hF, 4'hF, 4'hD, 4'hD, 4'h0};
  // Expected tick after edges 48..53 following the sync pulse (divisors 6,3,1,4).
  logic [3:0] tickE [0:5] = '{4'h4, 4'h4, 4'h6, 4'hC, 4'h4, 4'h7};

  clk_div_multi #(
    .N_CH    (N_CH),
    .CNT_W   (CNT_W),
    .DEF_DIV (DEFD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sync      (sync),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .pending   (pending),
    .tick      (tick),
    .clk_div   (clk_div)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count a comparison and report it when the observed value differs from the expected one.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Drive the configuration write port.
  task automatic applyStimulus(input logic valid, input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] dv);
    cfg_valid = valid;
    cfg_ch    = ch;
    cfg_div   = dv;
  endtask

  // Advance one clock edge and settle just after it.
  task automatic stepCycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic stepTo(input int target);
    while (cyc < target) stepCycle();
  endtask

  // Main directed sequence.
  initial begin
    rst  = 1'b0;
    en   = 4'hF;
    sync = 1'b0;
    applyStimulus(1'b0, 2'd0, 8'd0);

    // Reset state.
    stepCycle();
    stepCycle();
    checkOutput("rst.tick", tick, 4'h0);
    checkOutput("rst.clk_div", clk_div, 4'h0);
    checkOutput("rst.pending", pending, 4'h0);
    checkOutput("rst.ready", cfg_ready, 1'b1);
    rst = 1'b1;
    cyc = 0;

    // Default divisor of 4 on all channels, aligned.
    for (int e = 1; e <= 12; e++) begin
      stepCycle();
      checkOutput($sformatf("A.tick@%0d", e), tick, (e % 4 == 0) ? 4'hF : 4'h0);
      checkOutput($sformatf("A.clk_div@%0d", e), clk_div, ((e / 4) % 2 == 1) ? 4'hF : 4'h0);
    end
    checkOutput("A.pending", pending, 4'h0);

    // ch1 <= 3 written while counters sit at 1.
    stepTo(13);
    applyStimulus(1'b1, 2'd1, 8'd3);
    #1;
    checkOutput("B.ready_before", cfg_ready, 1'b1);
    stepTo(14);
    applyStimulus(1'b0, 2'd1, 8'd0);
    #1;
    checkOutput("B.pending14", pending, 4'h2);
    checkOutput("B.ready_ch1", cfg_ready, 1'b0);
    cfg_ch = 2'd0;
    #1;
    checkOutput("B.ready_ch0", cfg_ready, 1'b1);
    stepTo(15);
    checkOutput("B.pending15", pending, 4'h2);
    checkOutput("B.tick15", tick, 4'h0);
    stepTo(16);
    checkOutput("B.tick16", tick, 4'hF);
    checkOutput("B.pending16", pending, 4'h0);
    for (int e = 17; e <= 24; e++) begin
      stepCycle();
      checkOutput($sformatf("B.tick@%0d", e), tick, tickB[e-17]);
      checkOutput($sformatf("B.clk_div@%0d", e), clk_div, divB[e-17]);
    end

    // ch2 <= 0: stops at its next terminal with clk_div forced low.
    applyStimulus(1'b1, 2'd2, 8'd0);
    stepTo(25);
    checkOutput("C.pending25", pending, 4'h4);
    applyStimulus(1'b0, 2'd2, 8'd0);
    stepTo(28);
    checkOutput("C.tick28", tick, 4'hF);
    checkOutput("C.clk_div28", clk_div, 4'h9);
    checkOutput("C.pending28", pending, 4'h0);
    for (int e = 29; e <= 32; e++) begin
      stepCycle();
      checkOutput($sformatf("C.stop_tick@%0d", e), tick[2], 1'b0);
      checkOutput($sformatf("C.stop_div@%0d", e), clk_div[2], 1'b0);
    end

    // ch2 <= 1: applied from the stopped state, then ticks every cycle.
    applyStimulus(1'b1, 2'd2, 8'd1);
    stepTo(33);
    checkOutput("C.pending33", pending[2], 1'b1);
    checkOutput("C.tick33", tick[2], 1'b0);
    applyStimulus(1'b0, 2'd2, 8'd0);
    stepTo(34);
    checkOutput("C.pending34", pending[2], 1'b0);
    checkOutput("C.tick34", tick[2], 1'b0);
    stepTo(35);
    checkOutput("C.tick35", tick[2], 1'b1);
    checkOutput("C.div35", clk_div[2], 1'b1);
    stepTo(36);
    checkOutput("C.tick36", tick[2], 1'b1);
    checkOutput("C.div36", clk_div[2], 1'b0);
    stepTo(37);
    checkOutput("C.tick37", tick[2], 1'b1);

    // Freeze ch3 for 5 edges at cnt=1; its tick moves from 40 to 45.
    en = 4'b0111;
    for (int e = 38; e <= 42; e++) begin
      stepCycle();
      checkOutput($sformatf("D.frozen_tick@%0d", e), tick[3], 1'b0);
      if (e == 40) begin
        checkOutput("D.ch0_tick40", tick[0], 1'b1);
        checkOutput("D.frozen_div40", clk_div[3], 1'b1);
      end
    end
    en = 4'hF;
    stepTo(43);
    checkOutput("D.tick43", tick[3], 1'b0);
    stepTo(44);
    checkOutput("D.tick44", tick[3], 1'b0);
    checkOutput("D.ch0_tick44", tick[0], 1'b1);
    stepTo(45);
    checkOutput("D.tick45", tick[3], 1'b1);
    checkOutput("D.div45", clk_div[3], 1'b0);

    // ch0 <= 6 pending, then a sync pulse restarts every channel.
    applyStimulus(1'b1, 2'd0, 8'd6);
    stepTo(46);
    checkOutput("E.pending46", pending, 4'h1);
    applyStimulus(1'b0, 2'd0, 8'd0);
    sync = 1'b1;
    stepTo(47);
    sync = 1'b0;
    checkOutput("E.sync_tick", tick, 4'h0);
    checkOutput("E.sync_div", clk_div, 4'h0);
    checkOutput("E.sync_pending", pending, 4'h0);
    for (int e = 48; e <= 53; e++) begin
      stepCycle();
      checkOutput($sformatf("E.tick@%0d", e), tick, tickE[e-48]);
    end
    checkOutput("E.clk_div53", clk_div, 4'h9);

    // Reset in the middle of a period while ch3 holds a pending divisor.
    applyStimulus(1'b1, 2'd3, 8'd5);
    stepTo(54);
    applyStimulus(1'b0, 2'd3, 8'd0);
    checkOutput("F.pending54", pending, 4'h8);
    #1;
    checkOutput("F.ready_pend", cfg_ready, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("F.rst_tick", tick, 4'h0);
    checkOutput("F.rst_div", clk_div, 4'h0);
    checkOutput("F.rst_pending", pending, 4'h0);
    checkOutput("F.rst_ready", cfg_ready, 1'b1);
    stepCycle();
    stepCycle();
    rst = 1'b1;
    cyc = 0;
    for (int e = 1; e <= 8; e++) begin
      stepCycle();
      checkOutput($sformatf("F.tick@%0d", e), tick, (e % 4 == 0) ? 4'hF : 4'h0);
    end
    checkOutput("F.pending_after", pending, 4'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
